// File: rtl/adder_pkg.sv
// adder_pkg: shared types and defaults for the serial adder.
//   ADDER_WIDTH : default operand/result width
//   state_t     : controller state encoding (IDLE/RUN/DONE)
package adder_pkg;

   localparam int ADDER_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder.
//   A, B, Ci : addend bits and carry-in
//   S, Co    : sum bit and carry-out
module full_adder (
   input  logic A,
   input  logic B,
   input  logic Ci,
   output logic S,
   output logic Co
);

   assign S  = A ^ B ^ Ci;
   assign Co = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/serial_adder4.sv
// serial_adder4: bit-serial adder, one operand bit per clock, LSB first.
//   clk, rst    : clock and synchronous active-high reset
//   start       : begin an addition (honoured only when idle)
//   a, b, ci    : operands and carry-in, captured on the accepting edge
//   busy        : high while bits are being added
//   done        : one-cycle pulse when sum/co hold a new result
//   sum, co     : registered result a+b+ci (mod 2^WIDTH) and carry-out
module serial_adder4
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             co
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, s_q, sum_q;
   logic [WIDTH-1:0] s_d;
   logic [CW-1:0]    cnt_q;
   logic             c_q, co_q;
   logic             fa_s, fa_co;
   logic             accept, last;

   full_adder u_fa (
      .A  (a_q[0]),
      .B  (b_q[0]),
      .Ci (c_q),
      .S  (fa_s),
      .Co (fa_co)
   );

   assign accept = (state_q == IDLE) && start;
   assign last   = (state_q == RUN) && (cnt_q == LAST);
   // Sum bits enter at the MSB so after WIDTH shifts the LSB sits at bit 0.
   assign s_d    = {fa_s, s_q[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = (state_q == IDLE) ? (start ? RUN : IDLE) :
                (state_q == RUN)  ? (last ? DONE : RUN) : IDLE;
   end

   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         s_q   <= '0;
         c_q   <= 1'b0;
         cnt_q <= '0;
         sum_q <= '0;
         co_q  <= 1'b0;
      end else if (accept) begin
         a_q   <= a;
         b_q   <= b;
         c_q   <= ci;
         cnt_q <= '0;
      end else if (state_q == RUN) begin
         a_q   <= a_q >> 1;
         b_q   <= b_q >> 1;
         s_q   <= s_d;
         c_q   <= fa_co;
         cnt_q <= cnt_q + 1'b1;
         if (last) begin
            sum_q <= s_d;
            co_q  <= fa_co;
         end
      end
   end

   assign sum = sum_q;
   assign co  = co_q;

endmodule

// File: doc/serial_adder4.md
SERIAL_ADDER4 -- requirements
Module: serial_adder4

Interface
REQ-001 Parameter WIDTH, default 4, operand and result width in bits; legal range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on the edge that accepts start.
REQ-006 b  input  WIDTH  operand B; captured on the edge that accepts start.
REQ-007 ci  input  1  carry-in; captured on the edge that accepts start.
REQ-008 busy  output  1  high while state is RUN.
REQ-009 done  output  1  single-cycle pulse; result valid.
REQ-010 sum  output  WIDTH  registered result, a+b+ci modulo 2^WIDTH.
REQ-011 co  output  1  registered carry-out of the addition.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE, all registered.
REQ-013 In IDLE with start=1, the block SHALL load a, b into right-shift registers, load ci into the carry flop, clear the bit counter and enter RUN.
REQ-014 In IDLE with start=0, the block SHALL hold all state and outputs.
REQ-015 In RUN, each cycle SHALL use one full_adder on the operand LSBs and the carry flop, shift both operands right, shift the sum bit into the sum shift register MSB, update the carry flop, and increment the counter.
REQ-016 On the RUN cycle where the counter equals WIDTH-1, the block SHALL load sum/co from the completed shift register and carry, then enter DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-018 Latency: start accepted at edge k gives done=1 between edges k+WIDTH and k+WIDTH+1.
REQ-019 Back-to-back additions SHALL take a minimum of WIDTH+2 cycles from start to start.
REQ-020 sum and co SHALL change only on the edge entering DONE, and SHALL hold until the next completion.
REQ-021 start asserted in RUN or DONE SHALL be ignored; it SHALL NOT be queued.
REQ-022 Changes on a, b and ci after acceptance SHALL NOT affect the result in flight.
REQ-023 Overflow SHALL be reported only through co; sum SHALL wrap modulo 2^WIDTH.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE and clear the shift registers, counter, carry flop, sum, co, busy and done to 0.
REQ-025 rst SHALL take priority over start and over any in-flight operation; an aborted addition SHALL produce no done pulse.
REQ-026 The first start SHALL be accepted on the first edge with rst=0.

Structure
REQ-027 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default SHALL live in the shared package adder_pkg.
REQ-028 The per-bit arithmetic SHALL be one instance of the existing full_adder sub-module (A, B, Ci, S, Co); serial_adder4 SHALL contain no other arithmetic.
REQ-029 The counter SHALL be sized $clog2(WIDTH) bits.

Verification
REQ-030 The bench SHALL cover: a=0000, b=0000, ci=0 -> done 4 cycles after accept, sum=0000, co=0.
REQ-031 The bench SHALL cover: a=1100, b=0011, ci=0 -> sum=1111, co=0.
REQ-032 The bench SHALL cover: a=1111, b=0001, ci=0 -> sum=0000, co=1; then a=1010, b=0101, ci=1 -> sum=0000, co=1.
REQ-033 The bench SHALL cover: start held high for 10 cycles with operands changing every cycle -> exactly one done per WIDTH+2 cycles, each result matching the operands captured at acceptance.
REQ-034 The bench SHALL cover: rst pulsed 2 cycles after accept -> busy=0, sum=0000, co=0 next cycle, and no done pulse.
REQ-035 The bench SHALL cover: exhaustive sweep of all a, b, ci for WIDTH=4 -> {co,sum} equals a+b+ci every time, and done is high for exactly one cycle.
